sram_dma: RTL and testbench
===========================

Name: sram_dma

Overview:
- Block-copy/fill DMA engine directly upstream of the SRAM interface block; owns that block's bus inputs (address, write data, rw, cs, page).
- Normally passes the CPU bus straight through to the SRAM interface.
- When started via its 8 CPU-visible registers, it requests CPU halt, takes the bus after acknowledge, runs linear 64K read/write cycles, then returns the bus and optionally raises an interrupt.

Parameters:
- none (register map and widths fixed)

Ports:
- clk  in  1  system clock, same clock the SRAM interface uses for strobe phasing
- rst_n  in  1  asynchronous active-low reset
- reg_cs  in  1  register window select (decoded by the address decoder)
- reg_addr  in  3  register index
- reg_rw  in  1  1=read, 0=write
- reg_di  in  8  register write data
- reg_do  out  8  register read data (combinational from reg_addr)
- irq  out  1  level interrupt = done & irq_en
- halt_req  out  1  CPU halt request
- halt_ack  in  1  CPU has released the bus
- cpu_ad  in  16  CPU address
- cpu_di  in  8  CPU write data
- cpu_rw  in  1  CPU rw
- cpu_cs  in  1  CPU SRAM select
- cpu_page  in  5  page register value
- mem_ad  out  16  to SRAM interface address
- mem_di  out  8  to SRAM interface write data
- mem_rw  out  1  to SRAM interface rw
- mem_cs  out  1  to SRAM interface cs
- mem_page  out  5  to SRAM interface page
- mem_do  in  8  read data from SRAM interface

Behaviour:
- Register map (big-endian pairs):
  - 0 SRC_H, 1 SRC_L, 2 DST_H, 3 DST_L, 4 LEN_H, 5 LEN_L, 7 FILL (all R/W).
  - 6 CTRL/STATUS.
    - Write: bit0 start, bit1 irq_en (stored), bit2 fill mode (stored), bit3 abort, bit7 = 1 clears done.
    - Read: {done, 3'b0, abort_pend, fill, irq_en, busy}.
- Register writes occur on the rising edge with reg_cs & !reg_rw. SRC/DST/LEN/FILL writes while busy are ignored.
- Reset: all registers 0, state IDLE, halt_req=0, irq=0, done=0, bus in passthrough.
- FSM states: IDLE, HREQ, RD, WR, FIN.
  - IDLE: start with LEN≠0 -> HREQ, halt_req=1 from the next edge. Start with LEN=0 -> done=1, stays IDLE, no halt.
  - HREQ: waits for halt_ack sampled high -> RD (fill mode: WR). No timeout.
  - RD: one clk; mem_rw=1, mem_ad=SRC. mem_do is captured into the data register on the edge ending RD.
  - WR: one clk; mem_rw=0, mem_ad=DST, mem_di=data (fill mode: FILL). On the ending edge: SRC+1, DST+1 (16-bit wrap, FFFF->0000), LEN-1.
    - If the new LEN=0 or abort_pend: -> FIN.
    - Otherwise: -> RD (fill: WR).
  - FIN: halt_req=0, done=1, abort_pend=0 -> IDLE.
- Throughput: copy 2 clk/byte, fill 1 clk/byte. Start write to first RD cycle is 2 clk minimum (HREQ plus ack).
- Bus mux:
  - In RD/WR: mem_* driven by the DMA, mem_cs=1, mem_page=5'b0 (linear, no paging).
  - In all other states: mem_* = cpu_* passthrough, combinational.
- Abort:
  - Written while busy: sets abort_pend; the current byte completes, then FIN. SRC/DST/LEN hold their residual values.
  - Abort and start in the same write: abort wins, no start.
  - Abort while IDLE: ignored.
- Start while busy: ignored.
- done-clear write in the same cycle as FIN sets done: set wins.
- halt_ack dropping mid-transfer: ignored (protocol violation; no check).
- Reset mid-transfer: immediate IDLE, bus returns to CPU, halt_req=0. The partially written byte is undefined.
- SRC/DST overlap: no special handling; a strictly ascending copy is required behaviour.

Decomposition:
- Shared package holds:
  - register index constants (REG_SRC_H..REG_FILL)
  - CTRL bit positions
  - FSM state encoding (3-bit localparams)
- Natural sub-module: sram_dma_regs (register file plus read mux). FSM and bus mux stay in the top.

Test Plan:
- Passthrough: IDLE, cpu_ad=C123, cpu_rw=0, cpu_di=5A, cpu_page=0A -> mem_* equal cpu_* in the same cycle.
- Copy: SRC=1000, DST=2000, LEN=0004, CTRL=03, halt_ack 1 clk after halt_req -> 8 bus cycles; 2000..2003 equal 1000..1003; done=1; irq=1; halt_req=0; SRC=1004, LEN=0000.
- Fill with wrap: DST=FFFE, LEN=0003, FILL=E7, CTRL=05 -> writes to FFFE, FFFF, 0000, 1 clk each; mem_page=0 throughout.
- Zero length: LEN=0000, CTRL=01 -> halt_req never asserted; STATUS reads 80 next cycle.
- Abort: LEN=0010 copy, write CTRL=08 after 3rd WR -> exactly 4 bytes written, LEN=000C, done=1. A following CTRL=80 write clears done and irq.
- Reset mid-transfer: assert rst_n=0 during RD -> halt_req=0 and passthrough immediately; all registers read 00.

Source files
------------

// File: rtl/sram_dma_pkg.sv
// sram_dma_pkg: register indices, CTRL bit positions and FSM state encoding
// shared by the DMA top and its register file.
package sram_dma_pkg;

  // CPU-visible register indices (16-bit values are big-endian pairs)
  localparam logic [2:0] REG_SRC_H = 3'd0;
  localparam logic [2:0] REG_SRC_L = 3'd1;
  localparam logic [2:0] REG_DST_H = 3'd2;
  localparam logic [2:0] REG_DST_L = 3'd3;
  localparam logic [2:0] REG_LEN_H = 3'd4;
  localparam logic [2:0] REG_LEN_L = 3'd5;
  localparam logic [2:0] REG_CTRL  = 3'd6;
  localparam logic [2:0] REG_FILL  = 3'd7;

  // CTRL write bit positions
  localparam int unsigned CTRL_START    = 0;
  localparam int unsigned CTRL_IRQ_EN   = 1;
  localparam int unsigned CTRL_FILL     = 2;
  localparam int unsigned CTRL_ABORT    = 3;
  localparam int unsigned CTRL_CLR_DONE = 7;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HREQ = 3'd1,
    ST_RD   = 3'd2,
    ST_WR   = 3'd3,
    ST_FIN  = 3'd4
  } state_t;

endpackage

// File: rtl/sram_dma_regs.sv
// sram_dma_regs: CPU register file and read mux of the DMA engine.
//   reg_*      : CPU register window (write on rising edge when reg_cs & !reg_rw)
//   busy       : transfer in progress (SRC/DST/LEN/FILL writes ignored, start ignored)
//   step       : end of a WR cycle, advance SRC/DST and decrement LEN
//   fin        : FIN cycle, sets done and clears a pending abort
//   start_go   : accepted start with non-zero length, kicks the FSM
//   src..abort_pend : current register contents for the FSM and bus mux
module sram_dma_regs
  import sram_dma_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        reg_cs,
  input  logic [2:0]  reg_addr,
  input  logic        reg_rw,
  input  logic [7:0]  reg_di,
  output logic [7:0]  reg_do,
  input  logic        busy,
  input  logic        step,
  input  logic        fin,
  output logic        start_go,
  output logic [15:0] src,
  output logic [15:0] dst,
  output logic [15:0] len,
  output logic [7:0]  fill,
  output logic        irq_en,
  output logic        fill_mode,
  output logic        done,
  output logic        abort_pend
);

  logic wr_en;
  logic cfg_wr;
  logic ctrl_wr;
  logic start_cmd;
  logic abort_cmd;

  assign wr_en     = reg_cs & ~reg_rw;
  assign cfg_wr    = wr_en & ~busy;
  assign ctrl_wr   = wr_en & (reg_addr == REG_CTRL);
  // abort in the same write as start suppresses the start
  assign start_cmd = ctrl_wr & reg_di[CTRL_START] & ~reg_di[CTRL_ABORT] & ~busy;
  assign abort_cmd = ctrl_wr & reg_di[CTRL_ABORT] & busy;
  assign start_go  = start_cmd & (len != 16'h0000);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src        <= '0;
      dst        <= '0;
      len        <= '0;
      fill       <= '0;
      irq_en     <= 1'b0;
      fill_mode  <= 1'b0;
      done       <= 1'b0;
      abort_pend <= 1'b0;
    end else begin
      if (cfg_wr) begin
        case (reg_addr)
          REG_SRC_H: src[15:8] <= reg_di;
          REG_SRC_L: src[7:0]  <= reg_di;
          REG_DST_H: dst[15:8] <= reg_di;
          REG_DST_L: dst[7:0]  <= reg_di;
          REG_LEN_H: len[15:8] <= reg_di;
          REG_LEN_L: len[7:0]  <= reg_di;
          REG_FILL:  fill      <= reg_di;
          default: ;
        endcase
      end else if (step) begin
        src <= src + 16'd1;
        dst <= dst + 16'd1;
        len <= len - 16'd1;
      end

      if (ctrl_wr) begin
        irq_en    <= reg_di[CTRL_IRQ_EN];
        fill_mode <= reg_di[CTRL_FILL];
      end

      if (fin)
        abort_pend <= 1'b0;
      else if (abort_cmd)
        abort_pend <= 1'b1;

      // setting done takes priority over a simultaneous clear
      if (fin || (start_cmd && len == 16'h0000))
        done <= 1'b1;
      else if (ctrl_wr && reg_di[CTRL_CLR_DONE])
        done <= 1'b0;
    end
  end

  always_comb begin
    reg_do = '0;
    case (reg_addr)
      REG_SRC_H: reg_do = src[15:8];
      REG_SRC_L: reg_do = src[7:0];
      REG_DST_H: reg_do = dst[15:8];
      REG_DST_L: reg_do = dst[7:0];
      REG_LEN_H: reg_do = len[15:8];
      REG_LEN_L: reg_do = len[7:0];
      REG_CTRL:  reg_do = {done, 3'b000, abort_pend, fill_mode, irq_en, busy};
      REG_FILL:  reg_do = fill;
      default:   reg_do = '0;
    endcase
  end

endmodule

// File: rtl/sram_dma.sv
// sram_dma: block copy/fill DMA sitting in front of the SRAM interface.
// Passes the CPU bus through to mem_* unless it owns the bus (RD/WR states),
// in which case it drives linear 64K read/write cycles with page 0.
//   reg_*            : CPU register window, reg_do combinational
//   irq              : done & irq_en
//   halt_req/ack     : CPU bus handshake
//   cpu_*            : CPU side of the SRAM bus
//   mem_*            : SRAM interface side, mem_do is read data
module sram_dma
  import sram_dma_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        reg_cs,
  input  logic [2:0]  reg_addr,
  input  logic        reg_rw,
  input  logic [7:0]  reg_di,
  output logic [7:0]  reg_do,
  output logic        irq,
  output logic        halt_req,
  input  logic        halt_ack,
  input  logic [15:0] cpu_ad,
  input  logic [7:0]  cpu_di,
  input  logic        cpu_rw,
  input  logic        cpu_cs,
  input  logic [4:0]  cpu_page,
  output logic [15:0] mem_ad,
  output logic [7:0]  mem_di,
  output logic        mem_rw,
  output logic        mem_cs,
  output logic [4:0]  mem_page,
  input  logic [7:0]  mem_do
);

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  data;
  logic        busy;
  logic        step;
  logic        fin;
  logic        start_go;
  logic [15:0] src;
  logic [15:0] dst;
  logic [15:0] len;
  logic [7:0]  fill;
  logic        irq_en;
  logic        fill_mode;
  logic        done;
  logic        abort_pend;

  assign busy = (state != ST_IDLE);
  assign step = (state == ST_WR);
  assign fin  = (state == ST_FIN);
  assign irq  = done & irq_en;

  sram_dma_regs u_regs (
    .clk        (clk),
    .rst_n      (rst_n),
    .reg_cs     (reg_cs),
    .reg_addr   (reg_addr),
    .reg_rw     (reg_rw),
    .reg_di     (reg_di),
    .reg_do     (reg_do),
    .busy       (busy),
    .step       (step),
    .fin        (fin),
    .start_go   (start_go),
    .src        (src),
    .dst        (dst),
    .len        (len),
    .fill       (fill),
    .irq_en     (irq_en),
    .fill_mode  (fill_mode),
    .done       (done),
    .abort_pend (abort_pend)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      data  <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_RD)
        data <= mem_do;
    end
  end

  always_comb begin
    state_nxt = state;
    halt_req  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_go)
          state_nxt = ST_HREQ;
      end
      ST_HREQ: begin
        halt_req = 1'b1;
        if (halt_ack)
          state_nxt = fill_mode ? ST_WR : ST_RD;
      end
      ST_RD: begin
        halt_req  = 1'b1;
        state_nxt = ST_WR;
      end
      ST_WR: begin
        halt_req = 1'b1;
        // len is decremented on this edge, so 1 here means the last byte
        if (len == 16'd1 || abort_pend)
          state_nxt = ST_FIN;
        else
          state_nxt = fill_mode ? ST_WR : ST_RD;
      end
      ST_FIN:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_ad   = cpu_ad;
    mem_di   = cpu_di;
    mem_rw   = cpu_rw;
    mem_cs   = cpu_cs;
    mem_page = cpu_page;
    case (state)
      ST_RD: begin
        mem_ad   = src;
        mem_di   = data;
        mem_rw   = 1'b1;
        mem_cs   = 1'b1;
        mem_page = '0;
      end
      ST_WR: begin
        mem_ad   = dst;
        mem_di   = fill_mode ? fill : data;
        mem_rw   = 1'b0;
        mem_cs   = 1'b1;
        mem_page = '0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sram_dma.sv
module tb_sram_dma;
  import sram_dma_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        reg_cs;
  logic [2:0]  reg_addr;
  logic        reg_rw;
  logic [7:0]  reg_di;
  logic [7:0]  reg_do;
  logic        irq;
  logic        halt_req;
  logic        halt_ack;
  logic [15:0] cpu_ad;
  logic [7:0]  cpu_di;
  logic        cpu_rw;
  logic        cpu_cs;
  logic [4:0]  cpu_page;
  logic [15:0] mem_ad;
  logic [7:0]  mem_di;
  logic        mem_rw;
  logic        mem_cs;
  logic [4:0]  mem_page;
  logic [7:0]  mem_do;

  int n_tests;
  int n_fail;

  sram_dma dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .reg_cs   (reg_cs),
    .reg_addr (reg_addr),
    .reg_rw   (reg_rw),
    .reg_di   (reg_di),
    .reg_do   (reg_do),
    .irq      (irq),
    .halt_req (halt_req),
    .halt_ack (halt_ack),
    .cpu_ad   (cpu_ad),
    .cpu_di   (cpu_di),
    .cpu_rw   (cpu_rw),
    .cpu_cs   (cpu_cs),
    .cpu_page (cpu_page),
    .mem_ad   (mem_ad),
    .mem_di   (mem_di),
    .mem_rw   (mem_rw),
    .mem_cs   (mem_cs),
    .mem_page (mem_page),
    .mem_do   (mem_do)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // CPU model: releases the bus one clock after the request
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) halt_ack <= 1'b0;
    else        halt_ack <= halt_req;
  end

  // SRAM model: unwritten bytes read as addr_hi ^ addr_lo
  logic [7:0]  mem [0:65535];
  bit          written [0:65535];
  logic [15:0] wr_ad [0:63];
  logic [7:0]  wr_d  [0:63];
  int          wr_n;
  int          cyc_n;
  logic        pg_bad;
  logic        hr_seen;
  logic        clr_log;

  assign mem_do = written[mem_ad] ? mem[mem_ad] : (mem_ad[7:0] ^ mem_ad[15:8]);

  always @(posedge clk) begin
    if (clr_log) begin
      wr_n    <= 0;
      cyc_n   <= 0;
      pg_bad  <= 1'b0;
      hr_seen <= 1'b0;
    end else begin
      if (mem_cs && !mem_rw) begin
        mem[mem_ad]     <= mem_di;
        written[mem_ad] <= 1'b1;
        if (wr_n < 64) begin
          wr_ad[wr_n] <= mem_ad;
          wr_d[wr_n]  <= mem_di;
        end
        wr_n <= wr_n + 1;
      end
      if (mem_cs) begin
        cyc_n <= cyc_n + 1;
        if (mem_page != 5'd0) pg_bad <= 1'b1;
      end
      if (halt_req) hr_seen <= 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  // All tasks are entered just after a falling edge.
  task automatic clear_log();
    clr_log = 1'b1;
    @(negedge clk);
    clr_log = 1'b0;
  endtask

  task automatic reg_write(input logic [2:0] a, input logic [7:0] d);
    reg_cs = 1'b1; reg_rw = 1'b0; reg_addr = a; reg_di = d;
    @(negedge clk);
    reg_cs = 1'b0; reg_rw = 1'b1;
  endtask

  task automatic reg_read(input logic [2:0] a, output logic [7:0] d);
    reg_cs = 1'b1; reg_rw = 1'b1; reg_addr = a;
    #1;
    d = reg_do;
    reg_cs = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!halt_req) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [7:0] d;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if (halt_req !== 1'b0 || irq !== 1'b0) begin
      n_fail++; $display("FAIL reset_outputs: got halt_req=%b irq=%b expected 0 0", halt_req, irq);
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      reg_read(3'(i), d);
      n_tests++;
      if (d !== 8'h00) begin
        n_fail++; $display("FAIL reset_reg%0d: got %h expected 00", i, d);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_passthrough();
    cpu_ad = 16'hC123; cpu_rw = 1'b0; cpu_di = 8'h5A; cpu_cs = 1'b1; cpu_page = 5'h0A;
    #1;
    n_tests++;
    if ({mem_ad, mem_di, mem_rw, mem_cs, mem_page} !== {16'hC123, 8'h5A, 1'b0, 1'b1, 5'h0A}) begin
      n_fail++; $display("FAIL pass_a: got ad=%h di=%h rw=%b cs=%b pg=%h expected c123 5a 0 1 0a",
                         mem_ad, mem_di, mem_rw, mem_cs, mem_page);
    end
    cpu_ad = 16'h0001; cpu_rw = 1'b1; cpu_di = 8'hFF; cpu_cs = 1'b0; cpu_page = 5'h1F;
    #1;
    n_tests++;
    if ({mem_ad, mem_di, mem_rw, mem_cs, mem_page} !== {16'h0001, 8'hFF, 1'b1, 1'b0, 5'h1F}) begin
      n_fail++; $display("FAIL pass_b: got ad=%h di=%h rw=%b cs=%b pg=%h expected 0001 ff 1 0 1f",
                         mem_ad, mem_di, mem_rw, mem_cs, mem_page);
    end
    @(negedge clk);
  endtask

  task automatic test_copy();
    logic [7:0] d;
    bit ok;
    clear_log();
    reg_write(REG_SRC_H, 8'h10); reg_write(REG_SRC_L, 8'h00);
    reg_write(REG_DST_H, 8'h20); reg_write(REG_DST_L, 8'h00);
    reg_write(REG_LEN_H, 8'h00); reg_write(REG_LEN_L, 8'h04);
    reg_write(REG_CTRL, 8'h03);
    n_tests++;
    if (halt_req !== 1'b1) begin
      n_fail++; $display("FAIL copy_halt_req: got %b expected 1", halt_req);
    end
    wait_idle(ok);
    n_tests++;
    if (!ok) begin
      n_fail++; $display("FAIL copy_timeout: got busy expected idle");
    end
    n_tests++;
    if (cyc_n !== 8 || wr_n !== 4) begin
      n_fail++; $display("FAIL copy_cycles: got %0d bus/%0d wr expected 8/4", cyc_n, wr_n);
    end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (wr_ad[i] !== 16'h2000 + 16'(i) || wr_d[i] !== 8'h10 + 8'(i)) begin
        n_fail++; $display("FAIL copy_byte%0d: got %h@%h expected %h@%h",
                           i, wr_d[i], wr_ad[i], 8'h10 + 8'(i), 16'h2000 + 16'(i));
      end
    end
    n_tests++;
    if (pg_bad !== 1'b0 || irq !== 1'b1 || halt_req !== 1'b0) begin
      n_fail++; $display("FAIL copy_flags: got pg_bad=%b irq=%b halt_req=%b expected 0 1 0", pg_bad, irq, halt_req);
    end
    reg_read(REG_CTRL, d);
    n_tests++;
    if (d !== 8'h82) begin
      n_fail++; $display("FAIL copy_status: got %h expected 82", d);
    end
    reg_read(REG_SRC_L, d);
    n_tests++;
    if (d !== 8'h04) begin
      n_fail++; $display("FAIL copy_src_l: got %h expected 04", d);
    end
    reg_read(REG_LEN_L, d);
    n_tests++;
    if (d !== 8'h00) begin
      n_fail++; $display("FAIL copy_len_l: got %h expected 00", d);
    end
    @(negedge clk);
    reg_write(REG_CTRL, 8'h80);
    reg_read(REG_CTRL, d);
    n_tests++;
    if (d !== 8'h00 || irq !== 1'b0) begin
      n_fail++; $display("FAIL copy_clear: got status=%h irq=%b expected 00 0", d, irq);
    end
    @(negedge clk);
  endtask

  task automatic test_fill_wrap();
    logic [7:0]  d;
    logic [15:0] exp_ad [0:2];
    bit ok;
    exp_ad[0] = 16'hFFFE; exp_ad[1] = 16'hFFFF; exp_ad[2] = 16'h0000;
    cpu_page = 5'h15;
    clear_log();
    reg_write(REG_DST_H, 8'hFF); reg_write(REG_DST_L, 8'hFE);
    reg_write(REG_LEN_H, 8'h00); reg_write(REG_LEN_L, 8'h03);
    reg_write(REG_FILL, 8'hE7);
    reg_write(REG_CTRL, 8'h05);
    wait_idle(ok);
    n_tests++;
    if (!ok) begin
      n_fail++; $display("FAIL fill_timeout: got busy expected idle");
    end
    n_tests++;
    if (cyc_n !== 3 || wr_n !== 3 || pg_bad !== 1'b0) begin
      n_fail++; $display("FAIL fill_cycles: got %0d bus/%0d wr pg_bad=%b expected 3/3 0", cyc_n, wr_n, pg_bad);
    end
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (wr_ad[i] !== exp_ad[i] || wr_d[i] !== 8'hE7) begin
        n_fail++; $display("FAIL fill_byte%0d: got %h@%h expected e7@%h", i, wr_d[i], wr_ad[i], exp_ad[i]);
      end
    end
    reg_read(REG_DST_L, d);
    n_tests++;
    if (d !== 8'h01) begin
      n_fail++; $display("FAIL fill_dst_l: got %h expected 01", d);
    end
    reg_read(REG_CTRL, d);
    n_tests++;
    if (d !== 8'h84 || irq !== 1'b0) begin
      n_fail++; $display("FAIL fill_status: got %h irq=%b expected 84 0", d, irq);
    end
    @(negedge clk);
    reg_write(REG_CTRL, 8'h80);
  endtask

  task automatic test_zero_len();
    logic [7:0] d;
    clear_log();
    reg_write(REG_LEN_H, 8'h00); reg_write(REG_LEN_L, 8'h00);
    reg_write(REG_CTRL, 8'h01);
    reg_read(REG_CTRL, d);
    n_tests++;
    if (d !== 8'h80) begin
      n_fail++; $display("FAIL zero_status: got %h expected 80", d);
    end
    repeat (4) @(negedge clk);
    n_tests++;
    if (hr_seen !== 1'b0) begin
      n_fail++; $display("FAIL zero_halt: got halt_req seen=%b expected 0", hr_seen);
    end
    reg_write(REG_CTRL, 8'h80);
  endtask

  task automatic test_abort();
    logic [7:0] d;
    bit ok;
    clear_log();
    reg_write(REG_SRC_H, 8'h10); reg_write(REG_SRC_L, 8'h00);
    reg_write(REG_DST_H, 8'h30); reg_write(REG_DST_L, 8'h00);
    reg_write(REG_LEN_H, 8'h00); reg_write(REG_LEN_L, 8'h10);
    reg_write(REG_CTRL, 8'h03);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (wr_n >= 3) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_tests++;
    if (!ok) begin
      n_fail++; $display("FAIL abort_wait3: got %0d writes expected 3", wr_n);
    end
    reg_write(REG_CTRL, 8'h0A);
    wait_idle(ok);
    n_tests++;
    if (!ok || wr_n !== 4) begin
      n_fail++; $display("FAIL abort_count: got %0d writes idle=%b expected 4 1", wr_n, ok);
    end
    n_tests++;
    if (wr_ad[3] !== 16'h3003 || wr_d[3] !== 8'h13) begin
      n_fail++; $display("FAIL abort_last: got %h@%h expected 13@3003", wr_d[3], wr_ad[3]);
    end
    reg_read(REG_LEN_L, d);
    n_tests++;
    if (d !== 8'h0C) begin
      n_fail++; $display("FAIL abort_len_l: got %h expected 0c", d);
    end
    reg_read(REG_CTRL, d);
    n_tests++;
    if (d !== 8'h82 || irq !== 1'b1) begin
      n_fail++; $display("FAIL abort_status: got %h irq=%b expected 82 1", d, irq);
    end
    @(negedge clk);
    reg_write(REG_CTRL, 8'h82);
    reg_read(REG_CTRL, d);
    n_tests++;
    if (d !== 8'h02 || irq !== 1'b0) begin
      n_fail++; $display("FAIL abort_clear: got %h irq=%b expected 02 0", d, irq);
    end
    @(negedge clk);
    reg_write(REG_CTRL, 8'h00);
  endtask

  task automatic test_abort_start();
    logic [7:0] d;
    clear_log();
    reg_write(REG_LEN_H, 8'h00); reg_write(REG_LEN_L, 8'h05);
    reg_write(REG_CTRL, 8'h09);
    reg_read(REG_CTRL, d);
    n_tests++;
    if (d !== 8'h00) begin
      n_fail++; $display("FAIL abort_start_status: got %h expected 00", d);
    end
    repeat (3) @(negedge clk);
    n_tests++;
    if (hr_seen !== 1'b0) begin
      n_fail++; $display("FAIL abort_start_halt: got halt_req seen=%b expected 0", hr_seen);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    bit ok;
    cpu_ad = 16'h5A5A; cpu_di = 8'h3C; cpu_rw = 1'b1; cpu_cs = 1'b0; cpu_page = 5'h03;
    clear_log();
    reg_write(REG_SRC_H, 8'h10); reg_write(REG_SRC_L, 8'h00);
    reg_write(REG_DST_H, 8'h40); reg_write(REG_DST_L, 8'h00);
    reg_write(REG_LEN_H, 8'h00); reg_write(REG_LEN_L, 8'h10);
    reg_write(REG_CTRL, 8'h03);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (mem_cs && mem_rw) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_tests++;
    if (!ok || mem_ad !== 16'h1000 || mem_page !== 5'h00) begin
      n_fail++; $display("FAIL rst_mid_rd: got found=%b ad=%h pg=%h expected 1 1000 00", ok, mem_ad, mem_page);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (halt_req !== 1'b0 || irq !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_halt: got halt_req=%b irq=%b expected 0 0", halt_req, irq);
    end
    n_tests++;
    if ({mem_ad, mem_di, mem_rw, mem_cs, mem_page} !== {16'h5A5A, 8'h3C, 1'b1, 1'b0, 5'h03}) begin
      n_fail++; $display("FAIL rst_mid_pass: got ad=%h di=%h rw=%b cs=%b pg=%h expected 5a5a 3c 1 0 03",
                         mem_ad, mem_di, mem_rw, mem_cs, mem_page);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      reg_read(3'(i), d);
      n_tests++;
      if (d !== 8'h00) begin
        n_fail++; $display("FAIL rst_mid_reg%0d: got %h expected 00", i, d);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    reg_cs   = 1'b0;
    reg_rw   = 1'b1;
    reg_addr = 3'd0;
    reg_di   = 8'h00;
    cpu_ad   = 16'h0000;
    cpu_di   = 8'h00;
    cpu_rw   = 1'b1;
    cpu_cs   = 1'b0;
    cpu_page = 5'h00;
    clr_log  = 1'b1;
    @(negedge clk);
    test_reset();
    test_passthrough();
    cpu_cs   = 1'b0;
    cpu_page = 5'h1F;
    test_copy();
    test_fill_wrap();
    test_zero_len();
    test_abort();
    test_abort_start();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
